// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: 2-entry in-order skid buffer between two pipeline stages.
// Upstream side: in_valid/in_ready/in_instr/in_data. bubble writes a NOP entry
// instead of upstream data. flush empties the stage.
// Downstream side: out_valid/out_ready/out_instr/out_data. occupancy is 0..2.
// Clock clk, synchronous active-high reset rst.
// Optional macro PIPE_STAGE_BUF_STATS_EN adds the saturating bubble_cnt and
// stall_cnt outputs.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               bubble,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_data,
`ifdef PIPE_STAGE_BUF_STATS_EN
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        stall_cnt,
`endif
  output logic [1:0]         occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // head is the entry presented downstream, tail is the skid slot
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [DATA_W-1:0]  head_data_q, head_data_d;
  logic [INSTR_W-1:0] tail_instr_q, tail_instr_d;
  logic [DATA_W-1:0]  tail_data_q, tail_data_d;

  logic               not_full;
  logic               push;
  logic               wr_bubble;
  logic               wr;
  logic               pop;
  logic [INSTR_W-1:0] wr_instr;
  logic [DATA_W-1:0]  wr_data;

  assign not_full  = (state_q != FULL);
  assign in_ready  = not_full & ~bubble & ~flush;
  assign push      = in_valid & in_ready;
  assign wr_bubble = bubble & ~flush & not_full;
  assign wr        = push | wr_bubble;
  assign out_valid = (state_q != EMPTY);
  assign pop       = out_valid & out_ready;
  assign occupancy = state_q;

  // push and wr_bubble are mutually exclusive since in_ready masks bubble
  assign wr_instr = wr_bubble ? NOP_INSTR : in_instr;
  assign wr_data  = wr_bubble ? '0 : in_data;

  assign out_instr = out_valid ? head_instr_q : NOP_INSTR;
  assign out_data  = out_valid ? head_data_q : '0;

  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_data_d  = head_data_q;
    tail_instr_d = tail_instr_q;
    tail_data_d  = tail_data_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (wr) begin
            head_instr_d = wr_instr;
            head_data_d  = wr_data;
            state_d      = ONE;
          end
        end
        ONE: begin
          unique case ({wr, pop})
            2'b10: begin
              tail_instr_d = wr_instr;
              tail_data_d  = wr_data;
              state_d      = FULL;
            end
            // head leaves as the new entry arrives: it becomes the head
            2'b11: begin
              head_instr_d = wr_instr;
              head_data_d  = wr_data;
            end
            2'b01: state_d = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          // no write is possible while full
          if (pop) begin
            head_instr_d = tail_instr_q;
            head_data_d  = tail_data_q;
            state_d      = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      head_instr_q <= NOP_INSTR;
      head_data_q  <= '0;
      tail_instr_q <= NOP_INSTR;
      tail_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_data_q  <= head_data_d;
      tail_instr_q <= tail_instr_d;
      tail_data_q  <= tail_data_d;
    end
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (wr_bubble && bubble_cnt_q != 16'hFFFF) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
    if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and random checks of pipe_stage_buf against
// a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int DW = 64;
  localparam int IW = 16;
  localparam logic [IW-1:0] NOP = 16'h0800;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [DW-1:0] in_data;
  logic          bubble;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [15:0]   bubble_cnt;
  logic [15:0]   stall_cnt;
  int            m_bcnt;
  int            m_scnt;
`endif

  int total = 0;
  int bad = 0;

  logic [IW+DW-1:0] m_q[$];

  pipe_stage_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_data   (in_data),
    .bubble    (bubble),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_data  (out_data),
`ifdef PIPE_STAGE_BUF_STATS_EN
    .bubble_cnt(bubble_cnt),
    .stall_cnt (stall_cnt),
`endif
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] ins,
                       input logic [DW-1:0] d, input logic b,
                       input logic f, input logic ordy);
    rst = 1'b0;
    in_valid = v;
    in_instr = ins;
    in_data = d;
    bubble = b;
    flush = f;
    out_ready = ordy;
  endtask

  task automatic check_model();
    logic [IW+DW-1:0] h;
    h = (m_q.size() != 0) ? m_q[0] : {NOP, {DW{1'b0}}};
    chk("occupancy", 64'(occupancy), 64'(m_q.size()));
    chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    chk("out_instr", 64'(out_instr), 64'(h[IW+DW-1:DW]));
    chk("out_data", out_data, h[DW-1:0]);
    chk("in_ready", 64'(in_ready),
        64'(m_q.size() < 2 && !bubble && !flush));
`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bcnt));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
`endif
  endtask

  task automatic model_step();
    int n;
    logic rdy;
    n = m_q.size();
    rdy = (n < 2) && !bubble && !flush;
`ifdef PIPE_STAGE_BUF_STATS_EN
    if (rst) begin
      m_bcnt = 0;
      m_scnt = 0;
    end else begin
      if (bubble && !flush && n < 2 && m_bcnt < 65535) m_bcnt++;
      if (n > 0 && !out_ready && m_scnt < 65535) m_scnt++;
    end
`endif
    if (rst || flush) begin
      m_q.delete();
    end else begin
      if (n > 0 && out_ready) void'(m_q.pop_front());
      if (bubble && n < 2) m_q.push_back({NOP, {DW{1'b0}}});
      else if (in_valid && rdy) m_q.push_back({in_instr, in_data});
    end
  endtask

  // check current outputs, advance model and DUT by one clock
  task automatic cycle(input bit do_chk = 1'b1);
    #1;
    if (do_chk) check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0);
    cycle(1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'h0800);
    chk("rst_data", out_data, 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);

    // streaming
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h4123 + 16'(i), 64'(i + 100), 1'b0, 1'b0, 1'b1);
      cycle();
      chk("stream_instr", 64'(out_instr), 64'(16'h4123 + 16'(i)));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("drain_occ", 64'(occupancy), 64'd0);

    // backpressure
    drive(1'b1, 16'hA001, 64'h1, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'hA002, 64'h2, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'hA003, 64'h3, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bp_occ", 64'(occupancy), 64'd2);
    chk("bp_rdy", 64'(in_ready), 64'd0);
    cycle();
    chk("bp_hold", 64'(out_instr), 64'hA001);
    drive(1'b1, 16'hA003, 64'h3, 1'b0, 1'b0, 1'b1);
    chk("bp_out1", 64'(out_instr), 64'hA001);
    cycle();
    chk("bp_out2", 64'(out_instr), 64'hA002);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("bp_out3", 64'(out_instr), 64'hA003);
    cycle();
    chk("bp_empty", 64'(occupancy), 64'd0);

    // bubble
    drive(1'b1, 16'h6A00, 64'h55, 1'b1, 1'b0, 1'b1);
    #1;
    chk("bub_rdy", 64'(in_ready), 64'd0);
    cycle();
    chk("bub_instr", 64'(out_instr), 64'h0800);
    chk("bub_data", out_data, 64'd0);
    chk("bub_vld", 64'(out_valid), 64'd1);
    drive(1'b1, 16'h6A00, 64'h55, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("bub_next", 64'(out_instr), 64'h6A00);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle();

    // flush from full
    drive(1'b1, 16'hB001, 64'h9, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'hB002, 64'hA, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'hB003, 64'hB, 1'b1, 1'b1, 1'b0);
    cycle();
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_instr", 64'(out_instr), 64'h0800);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
            {32'($urandom), 32'($urandom)},
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 2) != 0));
      rst = 1'($urandom_range(0, 49) == 0);
      cycle();
    end

`ifdef PIPE_STAGE_BUF_STATS_EN
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    chk("st_bub", 64'(bubble_cnt), 64'd3);
    chk("st_stall", 64'(stall_cnt), 64'd5);
    for (int i = 0; i < 65540; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0);
    end
    chk("st_sat", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 64, meaning width of the side-band payload (register operands plus control bits).
REQ-002 Parameter INSTR_W, default 16, meaning width of the instruction field.
REQ-003 Parameter NOP_INSTR, default 16'h0800, meaning the encoding used for injected bubbles and for the empty-stage output.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream presents an entry.
REQ-007 in_ready  out  1  stage accepts an upstream entry this cycle.
REQ-008 in_instr  in  INSTR_W  upstream instruction.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 bubble  in  1  hazard stall: enqueue a NOP entry instead of upstream data.
REQ-011 flush  in  1  branch kill: discard all held entries.
REQ-012 out_valid  out  1  stage presents an entry downstream.
REQ-013 out_ready  in  1  downstream consumes the presented entry (low = memory stall).
REQ-014 out_instr  out  INSTR_W  head-entry instruction.
REQ-015 out_data  out  DATA_W  head-entry payload.
REQ-016 occupancy  out  2  number of held entries, 0 to 2.

Function
REQ-017 Storage is a 2-entry in-order skid buffer with states EMPTY (0), ONE (1) and FULL (2); occupancy shall equal the state encoding.
REQ-018 in_ready = (state != FULL) & ~bubble & ~flush; it is combinational from registered state and the bubble and flush inputs.
REQ-019 Push: in_valid & in_ready writes {in_instr, in_data} at the tail.
REQ-020 Bubble: bubble & ~flush & (state != FULL) writes {NOP_INSTR, 0} at the tail; in_instr and in_data are ignored that cycle.
REQ-021 Bubble while FULL: nothing is written, and the bubble request is not remembered.
REQ-022 Pop: out_valid & out_ready removes the head entry; the second entry, if any, becomes the head in the next cycle.
REQ-023 Push-or-bubble together with a pop in the same cycle: occupancy is unchanged and ordering is preserved.
REQ-024 Transitions: EMPTY to ONE on write; ONE to FULL on write without pop; FULL to ONE on pop; ONE to EMPTY on pop without write; otherwise the state holds.
REQ-025 out_valid = (state != EMPTY).
REQ-026 When EMPTY, out_instr = NOP_INSTR and out_data = 0.
REQ-027 Entries are held unchanged while out_ready is low, and no entry is dropped or duplicated.
REQ-028 Flush has highest priority: the next state is EMPTY, and any same-cycle push, bubble or pop has no effect on the next state.
REQ-029 Latency: an entry written into an EMPTY stage appears on the outputs one cycle later.
REQ-030 Throughput: one entry per cycle when out_ready is continuously high.

Reset
REQ-031 While rst is high at a clock edge, the next state is EMPTY, occupancy = 0, out_valid = 0, out_instr = NOP_INSTR and out_data = 0.
REQ-032 rst has priority over flush and all other inputs.
REQ-033 Reset mid-operation discards held entries, with no partial outputs in the cycle after reset.

Configuration
REQ-034 Macro PIPE_STAGE_BUF_STATS_EN: when defined, the block adds outputs bubble_cnt and stall_cnt (16 bits each, saturating at 16'hFFFF), cleared by rst only.
REQ-035 bubble_cnt increments on each cycle in which a bubble entry is written.
REQ-036 stall_cnt increments on each cycle in which out_valid & ~out_ready holds.
REQ-037 When PIPE_STAGE_BUF_STATS_EN is undefined, neither counter port nor counter logic exists, and all other behaviour is identical.

Verification
REQ-038 Reset then idle: rst for 2 cycles -> occupancy=0, out_valid=0, out_instr=16'h0800, in_ready=1.
REQ-039 Streaming: push instr 16'h4123/16'h4124/16'h4125 on consecutive cycles with out_ready=1 -> the same values appear on out_instr one cycle later each, in order, occupancy=1 throughout.
REQ-040 Backpressure: out_ready=0, push 16'hA001 then 16'hA002 -> occupancy=2 and in_ready=0; third push 16'hA003 held off by upstream; out_ready=1 -> outputs 16'hA001, 16'hA002, 16'hA003 in order, none lost.
REQ-041 Bubble: bubble=1 for one cycle with in_valid=1 and in_instr=16'h6A00 -> in_ready=0, next out_instr=16'h0800 with out_data=0; 16'h6A00 accepted the following cycle.
REQ-042 Flush: FULL with out_ready=0, then flush=1 together with in_valid=1 and bubble=1 -> next cycle occupancy=0 and out_instr=16'h0800, and no entry was written.
REQ-043 Stats (macro defined): 3 bubbles and 5 stall cycles -> bubble_cnt=3 and stall_cnt=5; counters forced to 16'hFFFE saturate at 16'hFFFF.
